// File: rtl/addr_decode_err_pkg.sv
// Shared types and constants for the address-decoder error responder.
package addr_decode_err_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDRAIN = 2'd1,
    RESP_R = 2'd2,
    RESP_W = 2'd3
  } err_state_e;

  localparam logic [31:0] DEFAULT_RESP_DATA = 32'hBADCAB1E;

endpackage

// File: rtl/err_resp_fifo.sv
// Request queue for the error responder: circular buffer with registered
// full/empty/count flags, so the upstream ready never depends on a same-cycle pop.
module err_resp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             data_i,
  output logic [Width-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  logic [Width-1:0]    r_mem [Depth];
  logic [PtrWidth-1:0] r_wr_ptr, r_rd_ptr;
  logic [CntWidth-1:0] r_count, w_count_next;
  logic                r_full, r_empty;
  logic                w_push, w_pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrWidth'(1);
  endfunction

  assign w_push = push_i && !r_full;
  assign w_pop  = pop_i && !r_empty;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) w_count_next = r_count + CntWidth'(1);
    else if (w_pop && !w_push) w_count_next = r_count - CntWidth'(1);
  end

  // NOTE: payload storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= w_count_next;
      r_full  <= (w_count_next == FullCnt);
      r_empty <= (w_count_next == '0);
    end
  end

  assign data_o  = r_mem[r_rd_ptr];
  assign full_o  = r_full;
  assign empty_o = r_empty;
  assign count_o = r_count;

endmodule

// File: rtl/addr_decode_err_resp.sv
// Terminating slave for an address decoder's error port: queues every request,
// drains write data, and answers in order with error responses.
module addr_decode_err_resp
  import addr_decode_err_pkg::*;
#(
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth  = 8,
  parameter int unsigned MaxTrans  = 4,
  parameter logic [31:0] RespData  = DEFAULT_RESP_DATA
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [IdWidth-1:0]   req_id_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic                 wdata_valid_i,
  output logic                 wdata_ready_o,
  input  logic                 wdata_last_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [IdWidth-1:0]   rsp_id_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_last_o,
  output logic                 rsp_err_o,
  output logic                 rsp_write_o,
  output logic                 busy_o
);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic                 write;
    logic [LenWidth-1:0]  len;
    logic [AddrWidth-1:0] addr;
  } req_entry_t;

  localparam int unsigned EntryWidth = $bits(req_entry_t);
  localparam int unsigned CntWidth   = $clog2(MaxTrans + 1);

  req_entry_t           w_push_entry, w_head, r_cur;
  logic                 w_full, w_empty, w_push, w_pop;
  logic [CntWidth-1:0]  w_count;
  err_state_e           r_state;
  logic [LenWidth-1:0]  r_beat;
  logic                 r_rsp_valid, r_rsp_last, r_rsp_write, r_wdata_ready;
  logic [IdWidth-1:0]   r_rsp_id;
  logic [DataWidth-1:0] r_rsp_data;
  logic                 w_unused_cur;

  assign w_push_entry = '{id: req_id_i, write: req_write_i, len: req_len_i, addr: req_addr_i};
  assign w_push       = req_valid_i && !w_full;
  assign w_pop        = (r_state == IDLE) && !w_empty;

  err_resp_fifo #(
    .Depth (MaxTrans),
    .Width (EntryWidth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_push_entry),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_cur         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_last    <= 1'b0;
      r_rsp_write   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_wdata_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_cur  <= w_head;
            r_beat <= '0;
            if (w_head.write) begin
              r_state       <= WDRAIN;
              r_wdata_ready <= 1'b1;
            end else begin
              r_state     <= RESP_R;
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_head.id;
              r_rsp_data  <= DataWidth'(RespData);
              r_rsp_last  <= (w_head.len == '0);
              r_rsp_write <= 1'b0;
            end
          end
        end
        WDRAIN: begin
          if (wdata_valid_i && wdata_last_i) begin
            r_state       <= RESP_W;
            r_wdata_ready <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_id      <= r_cur.id;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b1;
            r_rsp_write   <= 1'b1;
          end
        end
        RESP_R: begin
          if (rsp_ready_i) begin
            // Last is decided before the increment, so len='1 never wraps the counter.
            if (r_rsp_last) begin
              r_state     <= IDLE;
              r_rsp_valid <= 1'b0;
              r_rsp_last  <= 1'b0;
              r_rsp_id    <= '0;
              r_rsp_data  <= '0;
            end else begin
              r_beat     <= r_beat + LenWidth'(1);
              r_rsp_last <= ((r_beat + LenWidth'(1)) == r_cur.len);
            end
          end
        end
        RESP_W: begin
          if (rsp_ready_i) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_id    <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The address and write flag are kept in the current entry for debug visibility only.
  assign w_unused_cur = ^{r_cur.addr, r_cur.write};

  assign req_ready_o   = !w_full;
  assign wdata_ready_o = r_wdata_ready;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_id_o      = r_rsp_id;
  assign rsp_data_o    = r_rsp_data;
  assign rsp_last_o    = r_rsp_last;
  assign rsp_err_o     = r_rsp_valid;
  assign rsp_write_o   = r_rsp_write;
  assign busy_o        = (w_count != '0) || (r_state != IDLE);

endmodule
